// File: rtl/m_rect_fill.sv
// Rectangle fill engine: one command in, one vmem write per cycle out in raster order.
// Optional outline mode is compiled in with RECT_OUTLINE_EN.
module m_rect_fill #(
  parameter int unsigned P_W = 240,
  parameter int unsigned P_H = 240
) (
  input  logic        w_clk,
  input  logic        w_rst_n,
  input  logic        w_cmd_valid,
  output logic        w_cmd_ready,
  input  logic [7:0]  w_cmd_x0,
  input  logic [7:0]  w_cmd_y0,
  input  logic [7:0]  w_cmd_x1,
  input  logic [7:0]  w_cmd_y1,
  input  logic [15:0] w_cmd_color,
  input  logic        w_cmd_outline,
  input  logic        w_wr_ready,
  output logic        w_we,
  output logic [15:0] w_wadr,
  output logic [15:0] w_wdata,
  output logic        w_busy,
  output logic        w_done
);

  localparam logic [8:0] XLim  = 9'(P_W);
  localparam logic [8:0] YLim  = 9'(P_H);
  localparam logic [7:0] XLast = 8'(P_W - 1);
  localparam logic [7:0] YLast = 8'(P_H - 1);

  typedef enum logic [1:0] {StIdle, StClip, StFill, StDone} state_e;

  state_e      state_q, state_d;
  logic [7:0]  x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
  logic [15:0] color_q, color_d;
  logic [7:0]  xmin_q, xmin_d, xmax_q, xmax_d;
  logic [7:0]  ymin_q, ymin_d, ymax_q, ymax_d;
  logic [7:0]  x_q, x_d, y_q, y_d;
  logic        we_q, we_d;
  logic        outline_q, outline_d;

  // Sorted corners of the latched command, before clipping.
  logic [7:0] x_lo, x_hi, y_lo, y_hi;
  logic       jump_row;

  always_comb begin
    x_lo = (x0_q < x1_q) ? x0_q : x1_q;
    x_hi = (x0_q < x1_q) ? x1_q : x0_q;
    y_lo = (y0_q < y1_q) ? y0_q : y1_q;
    y_hi = (y0_q < y1_q) ? y1_q : y0_q;
  end

`ifdef RECT_OUTLINE_EN
  always_comb begin
    outline_d = outline_q;
    if (state_q == StIdle && w_cmd_valid) begin
      outline_d = w_cmd_outline;
    end
  end

  // On interior rows of an outline, skip straight from the left edge to the right edge.
  assign jump_row = outline_q && (y_q != ymin_q) && (y_q != ymax_q) && (x_q == xmin_q);
`else
  logic unused_outline;
  assign unused_outline = w_cmd_outline;
  assign outline_d      = 1'b0;
  assign jump_row       = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    x0_d    = x0_q;
    y0_d    = y0_q;
    x1_d    = x1_q;
    y1_d    = y1_q;
    color_d = color_q;
    xmin_d  = xmin_q;
    xmax_d  = xmax_q;
    ymin_d  = ymin_q;
    ymax_d  = ymax_q;
    x_d     = x_q;
    y_d     = y_q;
    we_d    = we_q;

    case (state_q)
      StIdle: begin
        if (w_cmd_valid) begin
          x0_d    = w_cmd_x0;
          y0_d    = w_cmd_y0;
          x1_d    = w_cmd_x1;
          y1_d    = w_cmd_y1;
          color_d = w_cmd_color;
          state_d = StClip;
        end
      end

      StClip: begin
        if ({1'b0, x_lo} >= XLim || {1'b0, y_lo} >= YLim) begin
          state_d = StDone;
        end else begin
          xmin_d  = x_lo;
          ymin_d  = y_lo;
          xmax_d  = (x_hi > XLast) ? XLast : x_hi;
          ymax_d  = (y_hi > YLast) ? YLast : y_hi;
          x_d     = x_lo;
          y_d     = y_lo;
          we_d    = 1'b1;
          state_d = StFill;
        end
      end

      StFill: begin
        if (we_q && w_wr_ready) begin
          if (x_q == xmax_q && y_q == ymax_q) begin
            we_d    = 1'b0;
            state_d = StDone;
          end else if (x_q == xmax_q) begin
            x_d = xmin_q;
            y_d = y_q + 8'd1;
          end else if (jump_row) begin
            x_d = xmax_q;
          end else begin
            x_d = x_q + 8'd1;
          end
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
        we_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      state_q   <= StIdle;
      x0_q      <= '0;
      y0_q      <= '0;
      x1_q      <= '0;
      y1_q      <= '0;
      color_q   <= '0;
      xmin_q    <= '0;
      xmax_q    <= '0;
      ymin_q    <= '0;
      ymax_q    <= '0;
      x_q       <= '0;
      y_q       <= '0;
      we_q      <= 1'b0;
      outline_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x0_q      <= x0_d;
      y0_q      <= y0_d;
      x1_q      <= x1_d;
      y1_q      <= y1_d;
      color_q   <= color_d;
      xmin_q    <= xmin_d;
      xmax_q    <= xmax_d;
      ymin_q    <= ymin_d;
      ymax_q    <= ymax_d;
      x_q       <= x_d;
      y_q       <= y_d;
      we_q      <= we_d;
      outline_q <= outline_d;
    end
  end

  // The cursor registers double as the write address.
  assign w_cmd_ready = (state_q == StIdle);
  assign w_busy      = (state_q != StIdle);
  assign w_done      = (state_q == StDone);
  assign w_we        = we_q;
  assign w_wadr      = {y_q, x_q};
  assign w_wdata     = color_q;

endmodule

// File: tb/tb_m_rect_fill.sv
// Scoreboard bench for m_rect_fill: driver pushes expected writes, monitor pops and compares.
module tb_m_rect_fill;

`ifdef RECT_OUTLINE_EN
  localparam bit OutEn = 1'b1;
`else
  localparam bit OutEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cx0 = '0, cy0 = '0, cx1 = '0, cy1 = '0;
  logic [15:0] ccol = '0;
  logic        cout = 1'b0;
  logic        wr_ready = 1'b1;
  logic        we, busy, done;
  logic [15:0] wadr, wdata;

  m_rect_fill dut (
    .w_clk        (clk),
    .w_rst_n      (rst_n),
    .w_cmd_valid  (cmd_valid),
    .w_cmd_ready  (cmd_ready),
    .w_cmd_x0     (cx0),
    .w_cmd_y0     (cy0),
    .w_cmd_x1     (cx1),
    .w_cmd_y1     (cy1),
    .w_cmd_color  (ccol),
    .w_cmd_outline(cout),
    .w_wr_ready   (wr_ready),
    .w_we         (we),
    .w_wadr       (wadr),
    .w_wdata      (wdata),
    .w_busy       (busy),
    .w_done       (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  int          wr_cnt = 0;
  int          first_we_cyc = -1;
  int          rdy_mode = 0;
  int          rdy_ph = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // 0: always ready, 1: random, 2: repeating 1,0,0.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: wr_ready = 1'b1;
      1: wr_ready = ($urandom_range(0, 3) != 0);
      default: begin
        wr_ready = (rdy_ph == 0);
        rdy_ph   = (rdy_ph + 1) % 3;
      end
    endcase
  end

  logic        stall_prev = 1'b0;
  logic [31:0] stall_val = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_prev) begin
        check("stall_we", {31'd0, we}, 32'd1);
        check("stall_word", {wadr, wdata}, stall_val);
      end
      stall_prev = we && !wr_ready;
      stall_val  = {wadr, wdata};
      if (we && first_we_cyc < 0) first_we_cyc = cyc;
      if (we && wr_ready) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_write: got %h want none", {wadr, wdata});
        end else begin
          check("write", {wadr, wdata}, exp_q.pop_front());
        end
      end
    end else begin
      stall_prev = 1'b0;
    end
  end

  // Reference: enumerate the clipped rectangle row by row.
  task automatic model(input logic [7:0] x0, y0, x1, y1, input logic [15:0] col,
                       input bit outl, output int n);
    int xl, xh, yl, yh;
    xl = (x0 < x1) ? x0 : x1;
    xh = (x0 < x1) ? x1 : x0;
    yl = (y0 < y1) ? y0 : y1;
    yh = (y0 < y1) ? y1 : y0;
    n  = 0;
    if (xl >= 240 || yl >= 240) return;
    if (xh > 239) xh = 239;
    if (yh > 239) yh = 239;
    for (int y = yl; y <= yh; y++) begin
      for (int x = xl; x <= xh; x++) begin
        if (!(OutEn && outl) || x == xl || x == xh || y == yl || y == yh) begin
          exp_q.push_back({8'(y), 8'(x), col});
          n++;
        end
      end
    end
  endtask

  task automatic send(input logic [7:0] x0, y0, x1, y1, input logic [15:0] col, input bit outl,
                      output int acc);
    int t;
    @(negedge clk);
    first_we_cyc = -1;
    cx0 = x0; cy0 = y0; cx1 = x1; cy1 = y1; ccol = col; cout = outl;
    cmd_valid = 1'b1;
    t = 0;
    while (!cmd_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    acc = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
    // Scramble the source fields so a design that fails to latch them shows it.
    cx0 = 8'($urandom); cy0 = 8'($urandom); cx1 = 8'($urandom); cy1 = 8'($urandom);
    ccol = 16'($urandom);
  endtask

  task automatic issue(input logic [7:0] x0, y0, x1, y1, input logic [15:0] col, input bit outl,
                       input bit lat, output int got);
    int n, acc, base, t;
    model(x0, y0, x1, y1, col, outl, n);
    base = wr_cnt;
    send(x0, y0, x1, y1, col, outl, acc);
    t = 0;
    while (!done && t < 70000) begin
      @(negedge clk);
      t++;
    end
    check("done_seen", {31'd0, done}, 32'd1);
    if (lat) begin
      check("done_latency", cyc - acc, 2 + n);
      if (n > 0) check("first_we_latency", first_we_cyc - acc, 32'd2);
    end
    got = wr_cnt - base;
    check("write_count", got, n);
    check("queue_empty", exp_q.size(), 32'd0);
    @(negedge clk);
    check("ready_after_done", {31'd0, cmd_ready}, 32'd1);
    check("done_pulse", {31'd0, done}, 32'd0);
  endtask

  initial begin
    int got, acc, t, base;
    logic [7:0] rx, ry;

    #23;
    check("rst_we", {31'd0, we}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_wadr", {16'd0, wadr}, 32'd0);
    check("rst_wdata", {16'd0, wdata}, 32'd0);
    check("rst_ready", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    issue(8'd10, 8'd20, 8'd12, 8'd21, 16'hF800, 1'b0, 1'b1, got);
    issue(8'd12, 8'd21, 8'd10, 8'd20, 16'hF800, 1'b0, 1'b1, got);
    issue(8'd230, 8'd235, 8'd250, 8'd250, 16'h07E0, 1'b0, 1'b1, got);
    issue(8'd245, 8'd0, 8'd250, 8'd5, 16'h001F, 1'b0, 1'b1, got);
    rdy_mode = 2;
    issue(8'd10, 8'd20, 8'd12, 8'd21, 16'hF800, 1'b0, 1'b0, got);
    rdy_mode = 0;
    issue(8'd0, 8'd0, 8'd3, 8'd3, 16'h1234, 1'b1, 1'b1, got);
    check("outline_writes", got, OutEn ? 32'd12 : 32'd16);
    issue(8'd5, 8'd9, 8'd5, 8'd2, 16'hABCD, 1'b1, 1'b1, got);
    issue(8'd236, 8'd100, 8'd255, 8'd104, 16'h5555, 1'b1, 1'b1, got);

    // Reset in the middle of a fill.
    begin
      int n;
      model(8'd0, 8'd0, 8'd50, 8'd50, 16'hBEEF, 1'b0, n);
      base = wr_cnt;
      send(8'd0, 8'd0, 8'd50, 8'd50, 16'hBEEF, 1'b0, acc);
      t = 0;
      while (wr_cnt < base + 3 && t < 100) begin
        @(negedge clk);
        t++;
      end
      check("pre_reset_writes", wr_cnt - base, 32'd3);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_we", {31'd0, we}, 32'd0);
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_wadr", {16'd0, wadr}, 32'd0);
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      base = wr_cnt;
      repeat (3) @(negedge clk);
      check("postrst_ready", {31'd0, cmd_ready}, 32'd1);
      check("postrst_no_writes", wr_cnt - base, 32'd0);
    end

    rdy_mode = 1;
    for (int i = 0; i < 40; i++) begin
      rx = 8'($urandom);
      ry = 8'($urandom);
      issue(rx, ry, 8'(int'(rx) + $urandom_range(0, 24) - 12),
            8'(int'(ry) + $urandom_range(0, 16) - 8), 16'($urandom), 1'($urandom), 1'b0, got);
    end
    rdy_mode = 0;
    for (int i = 0; i < 10; i++) begin
      rx = 8'($urandom_range(200, 255));
      ry = 8'($urandom_range(200, 255));
      issue(rx, ry, 8'($urandom_range(200, 255)), 8'($urandom_range(200, 255)),
            16'($urandom), 1'($urandom), 1'b1, got);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
